rst_mgmt_eth: RTL and testbench

- Reset sequencer that consumes the Ethernet PLL outputs. It drives the PLL reset and watches the PLL lock indication.
- It releases the Ethernet-domain reset request only after lock has been continuously stable for a programmable time.
- It runs on the free-running board clock, so it keeps working while the PLL output is stopped. On lock loss it re-resets the PLL, counts the event, and retries automatically on timeout.

---
 rtl/eth_rst_pkg.sv | 28 ++
 rtl/cdc_sync_bit.sv | 24 ++
 rtl/rst_mgmt_eth.sv | 129 ++++++++++++
 tb/tb_rst_mgmt_eth.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/eth_rst_pkg.sv
// Shared types and defaults for the Ethernet PLL reset sequencer.
package eth_rst_pkg;

  // Sequencer states, in the order a clean power-up walks through them.
  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } eth_rst_state_t;

  localparam int DEF_PLL_RST_CYCLES      = 16;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_SYNC_STAGES         = 2;

  // Width of the saturating lock-loss counter.
  localparam int RELOCK_W = 8;

  // Largest of three cycle counts; sizes the shared state counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return m;
  endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// N-stage single-bit synchronizer with synchronous clear to 0.
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync;

  // Shift the asynchronous bit through the flop chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= {STAGES{1'b0}};
    end else begin
      sync <= {sync[STAGES-2:0], d};
    end
  end

  assign q = sync[STAGES-1];

endmodule

// File: rtl/rst_mgmt_eth.sv
// Ethernet PLL reset sequencer: pulses the PLL reset, qualifies lock,
// then releases the Ethernet-domain reset request. Runs on the board clock.
module rst_mgmt_eth
  import eth_rst_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int SYNC_STAGES         = DEF_SYNC_STAGES
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                clk_locked_i,
  output logic                pll_rst_o,
  output logic                eth_rst_o,
  output logic                ready_o,
  output logic [RELOCK_W-1:0] relock_cnt_o,
  output logic                timeout_o
);

  localparam int CNT_MAX = max3(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] PLL_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

  localparam logic [RELOCK_W-1:0] RELOCK_MAX = {RELOCK_W{1'b1}};
  localparam logic [RELOCK_W-1:0] RELOCK_ONE = {{(RELOCK_W-1){1'b0}}, 1'b1};

  eth_rst_state_t   state;
  eth_rst_state_t   state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             lock_s;
  logic             timeout_evt;
  logic             relock_evt;

  cdc_sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk (clk_in),
    .rst (rst_in),
    .d   (clk_locked_i),
    .q   (lock_s)
  );

  // Next-state decode plus the single-cycle timeout / relock events.
  always_comb begin
    state_nxt   = state;
    timeout_evt = 1'b0;
    relock_evt  = 1'b0;
    case (state)
      PLL_RST: begin
        // Lock seen while the PLL is held in reset is meaningless; ignore it.
        if (cnt == PLL_LAST) begin
          state_nxt = WAIT_LOCK;
        end else begin
          state_nxt = PLL_RST;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          state_nxt   = PLL_RST;
          timeout_evt = 1'b1;
        end else begin
          state_nxt = WAIT_LOCK;
        end
      end
      STABLE: begin
        // Any drop restarts qualification from scratch via WAIT_LOCK.
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = RUN;
        end else begin
          state_nxt = STABLE;
        end
      end
      RUN: begin
        // A lock loss after release always gets a full PLL re-reset.
        if (!lock_s) begin
          state_nxt  = PLL_RST;
          relock_evt = 1'b1;
        end else begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = PLL_RST;
      end
    endcase
  end

  // State, shared counter and next-state-decoded registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= PLL_RST;
      cnt          <= CNT_ZERO;
      pll_rst_o    <= 1'b1;
      eth_rst_o    <= 1'b1;
      ready_o      <= 1'b0;
      relock_cnt_o <= {RELOCK_W{1'b0}};
      timeout_o    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        cnt <= CNT_ZERO;
      end else if (state == RUN) begin
        cnt <= CNT_ZERO;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
      pll_rst_o <= (state_nxt == PLL_RST);
      eth_rst_o <= (state_nxt != RUN);
      ready_o   <= (state_nxt == RUN);
      if (timeout_evt) begin
        timeout_o <= 1'b1;
      end
      if (relock_evt && (relock_cnt_o != RELOCK_MAX)) begin
        relock_cnt_o <= relock_cnt_o + RELOCK_ONE;
      end
    end
  end

endmodule

// File: tb/tb_rst_mgmt_eth.sv
// Directed scoreboard bench for rst_mgmt_eth with small test parameters.
module tb_rst_mgmt_eth;

  localparam int P = 4;
  localparam int T = 64;
  localparam int S = 8;
  localparam int N = 2;
  // Cycles from driving lock high to eth_rst_o low, and from a drop to reassertion.
  localparam int LAT_REL  = N + 1 + S;
  localparam int LAT_DROP = N + 1;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       clk_locked_i;
  logic       pll_rst_o;
  logic       eth_rst_o;
  logic       ready_o;
  logic [7:0] relock_cnt_o;
  logic       timeout_o;

  rst_mgmt_eth #(
    .PLL_RST_CYCLES      (P),
    .LOCK_TIMEOUT_CYCLES (T),
    .LOCK_STABLE_CYCLES  (S),
    .SYNC_STAGES         (N)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .clk_locked_i (clk_locked_i),
    .pll_rst_o    (pll_rst_o),
    .eth_rst_o    (eth_rst_o),
    .ready_o      (ready_o),
    .relock_cnt_o (relock_cnt_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  // Count rising edges so expectations can be scheduled by cycle.
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int         at;
    string      tag;
    logic [11:0] vec;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  logic final_chk = 1'b0;

  logic [11:0] obs;
  assign obs = {pll_rst_o, eth_rst_o, ready_o, timeout_o, relock_cnt_o};

  function automatic logic [11:0] v(input logic pll, input logic eth, input logic rdy,
                                    input logic to, input logic [7:0] rc);
    return {pll, eth, rdy, to, rc};
  endfunction

  task automatic expect_at(input int dly, input string tag, input logic [11:0] vec);
    exp_t e;
    e.at  = cyc + dly;
    e.tag = tag;
    e.vec = vec;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // Pop and compare every expectation due in the current cycle.
  always @(negedge clk_in) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        checks++;
        assert (obs === sb[i].vec) else begin
          fails++;
          $error("FAIL %s: observed {pll,eth,rdy,to,cnt}=%h expected %h at cycle %0d",
                 sb[i].tag, obs, sb[i].vec, cyc);
        end
        sb.delete(i);
      end
    end
    if (final_chk) begin
      checks++;
      assert (sb.size() == 0) else begin
        fails++;
        $error("FAIL sb_drain: observed %0d pending expected 0", sb.size());
      end
    end
  end

  initial begin
    logic [7:0] exp_rc;
    exp_rc       = 8'd0;
    rst_in       = 1'b1;
    clk_locked_i = 1'b0;

    // Power-up: three reset cycles, lock rises at cycle 10.
    tick(3);
    expect_at(0, "por_reset", v(1'b1, 1'b1, 1'b0, 1'b0, 8'd0));
    rst_in = 1'b0;
    expect_at(P - 1, "por_pll_hi", v(1'b1, 1'b1, 1'b0, 1'b0, 8'd0));
    expect_at(P,     "por_pll_lo", v(1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
    tick(7);
    clk_locked_i = 1'b1;
    expect_at(LAT_REL - 1, "por_pre_release", v(1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
    expect_at(LAT_REL,     "por_run",         v(1'b0, 1'b0, 1'b1, 1'b0, 8'd0));
    tick(LAT_REL + 2);

    // Lock never asserts: periodic PLL re-pulses and sticky timeout.
    clk_locked_i = 1'b0;
    rst_in = 1'b1;
    tick(1);
    expect_at(0, "t2_reset", v(1'b1, 1'b1, 1'b0, 1'b0, 8'd0));
    rst_in = 1'b0;
    expect_at(P - 1,         "t2_pll_hi0", v(1'b1, 1'b1, 1'b0, 1'b0, 8'd0));
    expect_at(P,             "t2_wait0",   v(1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
    expect_at(P + T - 1,     "t2_pre_to",  v(1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
    expect_at(P + T,         "t2_to1",     v(1'b1, 1'b1, 1'b0, 1'b1, 8'd0));
    expect_at(P + T + P - 1, "t2_pll_hi1", v(1'b1, 1'b1, 1'b0, 1'b1, 8'd0));
    expect_at(P + T + P,     "t2_wait1",   v(1'b0, 1'b1, 1'b0, 1'b1, 8'd0));
    expect_at(100,           "t2_eth_hi",  v(1'b0, 1'b1, 1'b0, 1'b1, 8'd0));
    expect_at(2 * (P + T),   "t2_to2",     v(1'b1, 1'b1, 1'b0, 1'b1, 8'd0));
    tick(140);

    // One-cycle lock glitch in STABLE restarts qualification.
    rst_in = 1'b1;
    tick(1);
    expect_at(0, "t3_reset_clears_to", v(1'b1, 1'b1, 1'b0, 1'b0, 8'd0));
    rst_in = 1'b0;
    tick(5);
    clk_locked_i = 1'b1;
    tick(5);
    clk_locked_i = 1'b0;
    tick(1);
    clk_locked_i = 1'b1;
    expect_at(5,           "t3_no_early_run", v(1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
    expect_at(LAT_REL - 1, "t3_pre_release",  v(1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
    expect_at(LAT_REL,     "t3_run",          v(1'b0, 1'b0, 1'b1, 1'b0, 8'd0));
    tick(LAT_REL + 4);

    // Lock glitch in RUN: full re-reset, lock high during PLL_RST ignored.
    clk_locked_i = 1'b0;
    exp_rc = 8'd1;
    expect_at(LAT_DROP - 1,        "t4_still_run", v(1'b0, 1'b0, 1'b1, 1'b0, 8'd0));
    expect_at(LAT_DROP,            "t4_drop",      v(1'b1, 1'b1, 1'b0, 1'b0, exp_rc));
    expect_at(LAT_DROP + P - 1,    "t4_pll_hi",    v(1'b1, 1'b1, 1'b0, 1'b0, exp_rc));
    expect_at(LAT_DROP + P,        "t4_wait",      v(1'b0, 1'b1, 1'b0, 1'b0, exp_rc));
    expect_at(LAT_DROP + P + S,    "t4_pre_rerun", v(1'b0, 1'b1, 1'b0, 1'b0, exp_rc));
    expect_at(LAT_DROP + P + S + 1, "t4_rerun",    v(1'b0, 1'b0, 1'b1, 1'b0, exp_rc));
    tick(1);
    clk_locked_i = 1'b1;
    tick(19);

    // 299 more lock losses: counter saturates at 255.
    for (int i = 0; i < 299; i++) begin
      if (exp_rc != 8'd255) begin
        exp_rc = exp_rc + 8'd1;
      end
      clk_locked_i = 1'b0;
      expect_at(LAT_DROP, "t5_relock", v(1'b1, 1'b1, 1'b0, 1'b0, exp_rc));
      tick(1);
      clk_locked_i = 1'b1;
      tick(17);
    end
    expect_at(0, "t5_sat_run", v(1'b0, 1'b0, 1'b1, 1'b0, 8'd255));
    tick(1);

    // Reset mid-RUN, then reset mid-STABLE.
    rst_in = 1'b1;
    tick(1);
    expect_at(0, "t6_run_reset", v(1'b1, 1'b1, 1'b0, 1'b0, 8'd0));
    rst_in = 1'b0;
    expect_at(P,     "t6_wait",   v(1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
    expect_at(P + 3, "t6_stable", v(1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
    tick(8);
    rst_in = 1'b1;
    tick(1);
    expect_at(0, "t6_stable_reset", v(1'b1, 1'b1, 1'b0, 1'b0, 8'd0));
    rst_in = 1'b0;
    expect_at(P + 1 + S - 1, "t6_pre_run",   v(1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
    expect_at(P + 1 + S,     "t6_final_run", v(1'b0, 1'b0, 1'b1, 1'b0, 8'd0));
    tick(15);

    final_chk = 1'b1;
    @(negedge clk_in);
    #1;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
